// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// The master side is fetch plus decode; the slave side is the queue itself.
interface if_id_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;

  modport master (
    output in_valid, in_pc, in_instruction, out_ready,
    input  in_ready, out_valid, out_pc, out_instruction
  );

  modport slave (
    input  in_valid, in_pc, in_instruction, out_ready,
    output in_ready, out_valid, out_pc, out_instruction
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID instruction queue. It holds {pc, instruction} pairs across decode stalls
// and drops all wrong-path entries when a branch is taken.
module if_id_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  if_id_buffer_if.slave    bus,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             push, pop;
  logic [63:0]      head;

  // Readiness depends only on occupancy, so there is no path from out_ready.
  assign bus.in_ready  = (count != CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);

  assign push = bus.in_valid  & bus.in_ready  & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  assign head                = mem[rd_ptr];
  assign bus.out_pc          = bus.out_valid ? head[63:32] : 32'h0;
  assign bus.out_instruction = bus.out_valid ? head[31:0]  : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_pc, bus.in_instruction};
  end
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, streaming, stall fill, wrap, flush.
module tb_if_id_buffer;
  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] count;
  int         checks;
  int         errors;

  if_id_buffer_if bus();

  if_id_buffer #(.DEPTH(2), .CNT_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bus.in_valid       = v;
    bus.in_pc          = pc;
    bus.in_instruction = ins;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset held across clock edges
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instruction, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b1;

    // Streaming with decode always ready
    bus.out_ready = 1'b1;
    drive(1'b1, 32'd4, 32'hE3A00001); tick();
    chk("str_count0", 32'(count), 32'd1);
    chk("str_pc0", bus.out_pc, 32'd4);
    chk("str_ins0", bus.out_instruction, 32'hE3A00001);
    drive(1'b1, 32'd8, 32'hE3A01002); tick();
    chk("str_count1", 32'(count), 32'd1);
    chk("str_pc1", bus.out_pc, 32'd8);
    chk("str_ins1", bus.out_instruction, 32'hE3A01002);
    drive(1'b1, 32'd12, 32'hE0802001); tick();
    chk("str_count2", 32'(count), 32'd1);
    chk("str_ins2", bus.out_instruction, 32'hE0802001);
    drive(1'b0, 32'h0, 32'h0); tick();
    chk("str_drain_count", 32'(count), 32'd0);
    chk("str_drain_valid", 32'(bus.out_valid), 32'd0);
    chk("str_drain_ins", bus.out_instruction, 32'h0);

    // Stall fill: the third push is refused
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd4, 32'hE3A00001); tick();
    chk("fill_count1", 32'(count), 32'd1);
    drive(1'b1, 32'd8, 32'hE3A01002); tick();
    chk("fill_count2", 32'(count), 32'd2);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'd12, 32'hE0802001); tick();
    chk("fill_no_ovf", 32'(count), 32'd2);
    chk("fill_head", bus.out_pc, 32'd4);
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1; tick();
    chk("drain_count1", 32'(count), 32'd1);
    chk("drain_pc8", bus.out_pc, 32'd8);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("drain_count0", 32'(count), 32'd0);
    tick();
    chk("empty_pop_no_udf", 32'(count), 32'd0);

    // Simultaneous push/pop at count=1, run through pointer wrap
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd4, 32'hA0000004); tick();
    chk("pp_head4", bus.out_pc, 32'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(8 + 4 * i), 32'hA0000000 | 32'(8 + 4 * i)); tick();
      chk("pp_count", 32'(count), 32'd1);
      chk("pp_pc", bus.out_pc, 32'(8 + 4 * i));
      chk("pp_ins", bus.out_instruction, 32'hA0000000 | 32'(8 + 4 * i));
    end

    // Flush at full with a valid input presented
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hA0000100); tick();
    chk("pre_flush_count", 32'(count), 32'd2);
    drive(1'b1, 32'd12, 32'hE0802001);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_pc", bus.out_pc, 32'h0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 32'h40, 32'hEA000010); tick();
    chk("tgt_pc", bus.out_pc, 32'h40);
    chk("tgt_ins", bus.out_instruction, 32'hEA000010);
    chk("tgt_count", 32'(count), 32'd1);

    // Flush with out_ready=1 at count=1: no pop, no underflow
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_pop_count", 32'(count), 32'd0);
    tick();
    chk("flush_pop_no_udf", 32'(count), 32'd0);
    chk("flush_pop_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-operation at count=2
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h50, 32'h1); tick();
    drive(1'b1, 32'h54, 32'h2); tick();
    chk("arst_pre_count", 32'(count), 32'd2);
    drive(1'b0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_pc", bus.out_pc, 32'h0);
    chk("arst_ins", bus.out_instruction, 32'h0);
    #1 rst = 1'b1;
    drive(1'b1, 32'h80, 32'hE1A00000); tick();
    chk("post_rst_push_count", 32'(count), 32'd1);
    chk("post_rst_push_pc", bus.out_pc, 32'h80);
    drive(1'b0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry (parameterizable) instruction queue between the instruction fetch stage and the instruction decode stage of the ARM pipeline. It captures each fetched {pc, instruction} pair, holds it while decode is frozen by the hazard unit, and discards all queued wrong-path instructions when a branch is taken. It replaces a plain IF/ID register so fetch can keep running one extra cycle across a decode stall.

## Interface

Parameters:
- DEPTH, 2, number of queue entries; power of two, minimum 2.
- CNT_W, 2, width of `count`; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  branch taken this cycle; discards queue contents and the current input.
- in_valid  input  1  fetch stage presents a valid entry.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  32  pc+4 value from fetch.
- in_instruction  input  32  fetched instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head entry this cycle (hazard unit drives `~freeze`).
- out_pc  output  32  head entry pc; 0 when `out_valid`=0.
- out_instruction  output  32  head entry instruction; 0 when `out_valid`=0 (bubble).
- count  output  CNT_W  number of occupied entries.

## Operation

- Storage: DEPTH×64-bit array, read pointer `rd_ptr`, write pointer `wr_ptr` (log2(DEPTH) bits each, wrap modulo DEPTH), occupancy `count` (0..DEPTH).
- `in_ready` = (count != DEPTH); depends only on registered state, with no combinational path from `out_ready`.
- `out_valid` = (count != 0); `out_pc`/`out_instruction` = entry[rd_ptr] when valid, else forced to 0.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- On push: entry[wr_ptr] ← {in_pc, in_instruction}; wr_ptr ← wr_ptr+1.
- On pop: rd_ptr ← rd_ptr+1.
- count ← count + push − pop. A simultaneous push and pop leaves count unchanged and is legal at any occupancy below full. At full, push is blocked even if a pop occurs in the same cycle.
- Flush takes priority over everything. On the clock edge with flush=1: count ← 0, rd_ptr ← 0, wr_ptr ← 0, and the entry presented that cycle is dropped. The array contents are don't-care.
- The array is not reset; only pointers and count are.
- Reset (rst=0, asynchronous): count=0, rd_ptr=0, wr_ptr=0. Outputs immediately become out_valid=0, in_ready=1, out_pc=0, out_instruction=0, count=0. Reset asserted mid-operation discards all entries in the same way. Deassertion is sampled synchronously, so the first push can occur on the first rising edge with rst=1.
- No state machine beyond occupancy. States are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), with transitions as above.

## Timing

- Latency: an entry pushed on edge t appears on out_* immediately after edge t, so decode sees it in cycle t+1.
- Throughput: one entry per cycle with out_ready held at 1. The queue then stays at count ≤ 1.
- A stall of N cycles with fetch running fills at most DEPTH entries. in_ready drops in the cycle after count reaches DEPTH.
- After a flush edge, out_valid=0 for at least one cycle. The first post-branch instruction pushed on the next edge is visible one cycle later.
- Empty queue with out_ready=1 does nothing, and count never underflows. Full queue with in_valid=1 does not write, and count never overflows.

## Test plan

- Reset: hold rst=0, toggle clk → count=0, out_valid=0, out_instruction=0, in_ready=1. Assert rst=0 asynchronously with count=2 → all of these take effect without waiting for a clock edge.
- Streaming: push pc=4,8,12 with instructions 0xE3A00001, 0xE3A01002, 0xE0802001 and out_ready=1 → decode sees them in the following cycles in order, count stays ≤1.
- Stall fill: out_ready=0 while pushing pc=4,8,12 → count=2 after two edges, in_ready=0, pc=12 not stored. Then set out_ready=1 → outputs show 4, then 8, and count goes 2→1→0.
- Simultaneous push/pop at count=1 (head pc=4, push pc=8) → count stays 1, out_pc=8 after the edge. Continue for 5 cycles to cover pointer wrap-around with no loss or duplication.
- Flush: count=2 with in_valid=1 (pc=12) and flush=1 for one edge → count=0, out_valid=0, pc=12 dropped. Next push of branch target pc=0x40 → out_pc=0x40 one cycle later.
- Flush with out_ready=1 and count=1 → no pop is counted, count=0, and no underflow.
